alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage directly downstream of alu_control: consumes its 4-bit control code plus two operands.
//  Produces the result and branch flags over a valid/ready handshake.
//  Logic/arith ops complete in 1 cycle; shifts iterate 1 bit/cycle unless fast shift is compiled in.
//  Sits between decode/alu_control and the writeback/branch-resolve logic.
// PARAMETERS
//  XLEN     32               datapath width
//  SHAMT_W  $clog2(XLEN)=5   shift-amount / shift-counter width
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  in_valid     in   1        operation presented
//  in_ready     out  1        unit can accept; transfer when in_valid && in_ready
//  control_in   in   4        code from alu_control (alu_pkg::ALU_*)
//  op_a         in   XLEN     rs1 / pc operand
//  op_b         in   XLEN     rs2 / immediate; shift amount = op_b[SHAMT_W-1:0]
//  out_valid    out  1        result/flags valid; held until out_ready
//  out_ready    in   1        consumer accepts; transfer when out_valid && out_ready
//  result       out  XLEN     registered result
//  zero         out  1        result == 0 (BEQ/BNE after SUB)
//  illegal      out  1        control_in not a defined code; result forced 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=0 during reset; result=0, zero=0, out_valid=0, illegal=0, counter=0.
//  FSM: IDLE -> (accept, non-shift or shamt==0) -> DONE; IDLE -> (accept, shift, shamt!=0) -> SHIFT;
//       SHIFT -> (counter==1) -> DONE; DONE -> (out_ready) -> IDLE, or straight to DONE/SHIFT on same-cycle accept.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back ops need no bubble.
//  Latency: non-shift 1 cycle (out_valid rises the cycle after accept); serial shift 1+shamt cycles.
//  Codes: ADD=0000 SUB=0001 XOR=0010 OR=0011 AND=0100 SLL=0101 SRL=0110 SRA=0111 SLT=1000 SLTU=1001.
//  ADD/SUB: modulo 2^XLEN, carry/overflow discarded. SLT signed compare, SLTU unsigned; result {XLEN-1 zeros, bit}.
//  SRA replicates op_a[XLEN-1] on each step. Shift counter loads shamt, decrements per SHIFT cycle.
//  Codes 1010-1111: result=0, illegal=1, zero=1, 1-cycle latency; never stall.
//  Outputs stable while out_valid && !out_ready; unchanged in IDLE after handshake (out_valid=0).
//  in_valid during SHIFT ignored (in_ready=0); operands captured at accept, later input changes irrelevant.
//  Reset asserted mid-SHIFT aborts op; no result emitted after release.
// CONFIGURATION
//  ALU_FAST_SHIFT_EN defined: shifts use a barrel shifter, 1-cycle latency; SHIFT state and counter unreachable/removed.
//  Undefined (default): serial shifter as above, latency 1+shamt.
// STRUCTURE
//  alu_pkg: XLEN default, ALU_* 4-bit code localparams, state encoding (IDLE/SHIFT/DONE), alu_code_is_shift() function.
//  Sub-module alu_shift_step: one-bit combinational shift (dir, arith) reused per SHIFT cycle; top holds FSM and regs.
// TESTING
//  ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, zero=0, out_valid 1 cycle after accept.
//  SUB 5-5 -> result 0, zero=1; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
//  SRA op_a=0x80000000 shamt=4 -> 0xF8000000, out_valid after 5 cycles (1 with ALU_FAST_SHIFT_EN); shamt=0 -> 1 cycle.
//  out_ready=0 for 3 cycles after result -> result/out_valid held, in_ready=0; then back-to-back AND, OR with out_ready=1 -> one result per cycle.
//  control_in=1111 -> illegal=1, result=0, 1-cycle latency; next legal op clears illegal.
//  rst_n low mid-SLL shamt=31 -> all outputs 0 asynchronously; after release no stale out_valid, next ADD correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: operation codes, FSM state encoding and helpers.
// Consumers compile with ALU_FAST_SHIFT_EN to select the single-cycle barrel shifter.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic alu_code_is_shift(input logic [3:0] code);
    return code inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shift used once per SHIFT cycle by the serial shifter.
module alu_shift_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] shifted
);

  always_comb begin
    if (left) shifted = {value[XLEN-2:0], 1'b0};
    else      shifted = {arith & value[XLEN-1], value[XLEN-1:1]};
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage with valid/ready on both sides; shifts run 1 bit/cycle by default,
// or in one cycle through a barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      control_in,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  state_t state, state_next;

  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic               go_shift;
  logic               shift_done;
  logic [XLEN-1:0]    shift_res;
  logic [XLEN-1:0]    alu_res;
  logic               alu_ill;

  assign shamt    = op_b[SHAMT_W-1:0];
  // Held low during reset so upstream cannot hand over an op that would be dropped.
  assign in_ready = rst_n && ((state == IDLE) || (state == DONE && out_ready));
  assign accept   = in_valid && in_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (control_in)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
      // Only reached with shamt == 0; non-zero amounts go through the SHIFT state.
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`endif
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      default:  alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift   = 1'b0;
  assign shift_done = 1'b0;
  assign shift_res  = '0;
`else
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    shift_q;
  logic [3:0]         shift_code;

  alu_shift_step #(.XLEN(XLEN)) u_shift_step (
    .value   (shift_q),
    .left    (shift_code == ALU_SLL),
    .arith   (shift_code == ALU_SRA),
    .shifted (shift_res)
  );

  assign go_shift   = alu_code_is_shift(control_in) && (shamt != '0);
  assign shift_done = (state == SHIFT) && (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shift_q    <= '0;
      shift_code <= '0;
    end else if (accept && go_shift) begin
      cnt        <= shamt;
      shift_q    <= op_a;
      shift_code <= control_in;
    end else if (state == SHIFT) begin
      cnt     <= cnt - SHAMT_W'(1);
      shift_q <= shift_res;
    end
  end
`endif

  always_comb begin
    state_next = state;
    if (accept)                          state_next = go_shift ? SHIFT : DONE;
    else if (shift_done)                 state_next = DONE;
    else if (state == DONE && out_ready) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept && !go_shift) begin
      result    <= alu_res;
      zero      <= (alu_res == '0);
      illegal   <= alu_ill;
      out_valid <= 1'b1;
    end else if (shift_done) begin
      result    <= shift_res;
      zero      <= (shift_res == '0);
      illegal   <= 1'b0;
      out_valid <= 1'b1;
    end else if (accept || (state == DONE && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus backpressure and mid-shift reset sequences.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control_in;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .control_in (control_in),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int shift_lat(input int amount);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (amount == 0) ? 1 : 1 + amount;
`endif
  endfunction

  task automatic run_op(input vec_t v);
    int lat;
    int guard;
    @(negedge clk);
    in_valid   = 1'b1;
    control_in = v.code;
    op_a       = v.a;
    op_b       = v.b;
    guard      = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({v.name, "_accept_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    control_in = 4'($urandom_range(0, 15));
    op_a       = $urandom;
    op_b       = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, "_result"}, result, v.exp_res);
    check({v.name, "_zero"}, 32'(zero), 32'(v.exp_zero));
    check({v.name, "_illegal"}, 32'(illegal), 32'(v.exp_ill));
    @(posedge clk);
    #1;
    check({v.name, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;

    vecs.push_back('{"add_ovf",   ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{"sub_eq",    ALU_SUB,  32'd5,         32'd5,         32'h0000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{"slt_neg",   ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1});
    vecs.push_back('{"sltu_big",  ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{"xor",       ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1});
    vecs.push_back('{"or",        ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1});
    vecs.push_back('{"and",       ALU_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0, 1});
    vecs.push_back('{"add_wrap",  ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1});
    vecs.push_back('{"sra4",      ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1'b0, shift_lat(4)});
    vecs.push_back('{"sra0_mask", ALU_SRA,  32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 1'b0, 1'b0, shift_lat(0)});
    vecs.push_back('{"sra_pos",   ALU_SRA,  32'h4000_0000, 32'd2,         32'h1000_0000, 1'b0, 1'b0, shift_lat(2)});
    vecs.push_back('{"srl3",      ALU_SRL,  32'h8000_0000, 32'd3,         32'h1000_0000, 1'b0, 1'b0, shift_lat(3)});
    vecs.push_back('{"sll31",     ALU_SLL,  32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1'b0, shift_lat(31)});
    vecs.push_back('{"ill_1111",  4'b1111,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1});
    vecs.push_back('{"add_clr",   ALU_ADD,  32'd100,       32'd23,        32'd123,       1'b0, 1'b0, 1});
    vecs.push_back('{"ill_1010",  4'b1010,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1});
    vecs.push_back('{"sub_neg",   ALU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0, 1});

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    control_in = '0;
    op_a       = '0;
    op_b       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Backpressure: result held three cycles, then AND and OR stream back to back.
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    control_in = ALU_ADD;
    op_a       = 32'd2;
    op_b       = 32'd3;
    @(posedge clk);
    #1;
    check("bp_first_valid", 32'(out_valid), 32'd1);
    control_in = ALU_AND;
    op_a       = 32'hFF00_FF00;
    op_b       = 32'h0F0F_0F0F;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", result, 32'd5);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_and_valid", 32'(out_valid), 32'd1);
    check("b2b_and_result", result, 32'h0F00_0F00);
    control_in = ALU_OR;
    op_a       = 32'hF000_0000;
    op_b       = 32'h0000_000F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_or_valid", 32'(out_valid), 32'd1);
    check("b2b_or_result", result, 32'hF000_000F);
    @(posedge clk);
    #1;
    check("b2b_drain_valid", 32'(out_valid), 32'd0);
    check("b2b_drain_result", result, 32'hF000_000F);

    // Reset in the middle of a long serial shift.
    @(negedge clk);
    in_valid   = 1'b1;
    control_in = ALU_SLL;
    op_a       = 32'h0000_0001;
    op_b       = 32'd31;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd0);
    check("mid_rst_illegal", 32'(illegal), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("post_rst_no_stale", 32'(seen), 32'd0);
    run_op('{"post_rst_add", ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
